bcd_counter_updn: RTL and testbench

//   Parametrised N-digit synchronous BCD counter for the Counter library. Counts up or

---
 rtl/bcd_counter_updn.sv | 81 ++++++++
 tb/tb_bcd_counter_updn.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_updn.sv
// N-digit synchronous BCD up/down counter with clear, parallel load, per-digit
// advance enables, terminal-count carry and a sticky wrap/saturation flag.
module bcd_counter_updn #(
  parameter int DIGITS    = 4,
  parameter bit WRAP_STOP = 1'b0,
  localparam int QW       = 4 * DIGITS,
  localparam int ENA_W    = (DIGITS > 1) ? DIGITS - 1 : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [QW-1:0]    load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [QW-1:0]    q,
  output logic [ENA_W-1:0] ena,
  output logic             carry_out,
  output logic             wrapped
);

  logic            count;
  logic            run;
  logic [DIGITS:0] chain;
  logic [QW-1:0]   q_step;
  logic [QW-1:0]   q_load;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [3:0] bcd_step(input logic [3:0] d, input logic up);
    if (up) return (d == 4'd9) ? 4'd0 : d + 4'd1;
    return (d == 4'd0) ? 4'd9 : d - 4'd1;
  endfunction

  assign count = en & ~clr & ~load;

  // chain[i] is high when every digit below i sits at the terminal value for
  // the current direction; each nibble steps on its own, no binary carry.
  always_comb begin
    run    = 1'b1;
    chain  = '0;
    q_step = q;
    q_load = '0;
    for (int i = 0; i < DIGITS; i++) begin
      chain[i] = run;
      run      = run & (up_dn ? (q[4*i +: 4] == 4'd9) : (q[4*i +: 4] == 4'd0));
      q_step[4*i +: 4] = chain[i] ? bcd_step(q[4*i +: 4], up_dn) : q[4*i +: 4];
      q_load[4*i +: 4] = bcd_clamp(load_val[4*i +: 4]);
    end
    chain[DIGITS] = run;
  end

  generate
    if (DIGITS > 1) begin : g_ena
      assign ena = {ENA_W{count}} & chain[DIGITS-1:1];
    end else begin : g_no_ena
      assign ena = 1'b0;
    end
  endgenerate

  assign carry_out = count & chain[DIGITS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q       <= '0;
      wrapped <= 1'b0;
    end else if (clr) begin
      q       <= '0;
      wrapped <= 1'b0;
    end else if (load) begin
      q <= q_load;
    end else if (count) begin
      // In saturating mode the terminal value is held instead of wrapping.
      if (!(carry_out && WRAP_STOP)) q <= q_step;
      if (carry_out) wrapped <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bcd_counter_updn.sv
// Bench for bcd_counter_updn: a wrapping and a saturating 4-digit instance share
// stimulus; a decimal model predicts results into a scoreboard queue.
module tb_bcd_counter_updn;

  logic        clk;
  logic        reset;
  logic        clr;
  logic        load;
  logic [15:0] load_val;
  logic        en;
  logic        up_dn;

  logic [15:0] q_w, q_s;
  logic [2:0]  ena_w, ena_s;
  logic        carry_w, carry_s;
  logic        wrapped_w, wrapped_s;

  typedef struct packed {
    logic [15:0] qw;
    logic        ww;
    logic [15:0] qs;
    logic        ws;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   mv_w = 0, mv_s = 0;
  logic mw_w = 1'b0, mw_s = 1'b0;

  bcd_counter_updn #(.DIGITS(4), .WRAP_STOP(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .q(q_w), .ena(ena_w), .carry_out(carry_w),
    .wrapped(wrapped_w)
  );

  bcd_counter_updn #(.DIGITS(4), .WRAP_STOP(1'b1)) u_sat (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up_dn(up_dn), .q(q_s), .ena(ena_s), .carry_out(carry_s),
    .wrapped(wrapped_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] b;
    int t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      b[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  function automatic int load2int(input logic [15:0] b);
    int v, d;
    v = 0;
    for (int i = 3; i >= 0; i--) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic logic [2:0] exp_ena(input int v);
    logic [2:0] e;
    int p;
    for (int i = 1; i <= 3; i++) begin
      p = 10 ** i;
      e[i-1] = en && !clr && !load && (up_dn ? (v % p == p - 1) : (v % p == 0));
    end
    return e;
  endfunction

  function automatic logic exp_carry(input int v);
    return en && !clr && !load && (up_dn ? (v == 9999) : (v == 0));
  endfunction

  task automatic model_next(inout int v, inout logic w, input bit sat);
    if (clr) begin
      v = 0;
      w = 1'b0;
    end else if (load) begin
      v = load2int(load_val);
    end else if (en) begin
      if (up_dn) begin
        if (v == 9999) begin w = 1'b1; if (!sat) v = 0; end
        else v = v + 1;
      end else begin
        if (v == 0) begin w = 1'b1; if (!sat) v = 9999; end
        else v = v - 1;
      end
    end
  endtask

  task automatic check_comb();
    check("ena_wrap",   32'(ena_w),   32'(exp_ena(mv_w)));
    check("carry_wrap", 32'(carry_w), 32'(exp_carry(mv_w)));
    check("ena_sat",    32'(ena_s),   32'(exp_ena(mv_s)));
    check("carry_sat",  32'(carry_s), 32'(exp_carry(mv_s)));
  endtask

  task automatic push_exp();
    exp_t e;
    model_next(mv_w, mw_w, 1'b0);
    model_next(mv_s, mw_s, 1'b1);
    e.qw = int2bcd(mv_w);
    e.ww = mw_w;
    e.qs = int2bcd(mv_s);
    e.ws = mw_s;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("q_wrap",       32'(q_w),       32'(e.qw));
      check("wrapped_wrap", 32'(wrapped_w), 32'(e.ww));
      check("q_sat",        32'(q_s),       32'(e.qs));
      check("wrapped_sat",  32'(wrapped_s), 32'(e.ws));
    end
  endtask

  task automatic cycle(input logic c, input logic l, input logic [15:0] lv,
                       input logic e, input logic u);
    @(negedge clk);
    clr = c; load = l; load_val = lv; en = e; up_dn = u;
    #1;
    check_comb();
    push_exp();
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; up_dn = 1'b1;
    #3;
    check("rst_q_wrap",       32'(q_w),       32'h0);
    check("rst_wrapped_wrap", 32'(wrapped_w), 32'h0);
    check("rst_q_sat",        32'(q_s),       32'h0);
    check("rst_wrapped_sat",  32'(wrapped_s), 32'h0);
    check_comb();
    @(negedge clk);
    reset = 1'b1;

    // Free count up 1000 edges from reset
    repeat (1000) cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    check("t1_q", 32'(q_w), 32'h1000);

    // Wrap / saturate at 9999 counting up
    cycle(1'b0, 1'b1, 16'h9998, 1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

    // Clamped load keeps wrapped; clr beats load
    cycle(1'b0, 1'b1, 16'hA5F3, 1'b1, 1'b1);
    check("t4_clamp", 32'(q_w), 32'h9593);
    cycle(1'b1, 1'b1, 16'h1234, 1'b1, 1'b1);

    // Wrap / saturate at 0000 counting down
    cycle(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);

    // Async reset between edges, then count on the first edge after release
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
    repeat (42) cycle(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    check("t5_q42", 32'(q_w), 32'h0042);
    @(negedge clk);
    clr = 1'b0; load = 1'b0; en = 1'b0; up_dn = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("t5_async_q_wrap", 32'(q_w), 32'h0);
    check("t5_async_q_sat",  32'(q_s), 32'h0);
    mv_w = 0; mw_w = 1'b0; mv_s = 0; mw_s = 1'b0;
    en = 1'b1;
    #1 reset = 1'b1;
    push_exp();
    @(posedge clk);
    #1;
    pop_check();
    check("t5_first", 32'(q_w), 32'h0001);

    // Direction toggled every cycle
    cycle(1'b0, 1'b1, 16'h0050, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 16'h0, 1'b1, (k % 2 == 0));

    // en=0 holds at terminal; clr/load suppress carry and ena
    cycle(1'b0, 1'b1, 16'h9999, 1'b0, 1'b1);
    repeat (2) cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 16'h9999, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 16'h0, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);

    // Mixed random traffic
    for (int k = 0; k < 300; k++) begin
      cycle(($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0),
            16'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
